// File: rtl/bin2qdi_1ofn_fifo_if.sv
// Binary-side push bus and 1-of-N rail bus of the binary-to-QDI source.
// The master drives words and the circuit enable; the slave is the source itself.
interface bin2qdi_1ofn_fifo_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned L = $clog2(N);

  logic [DIGITS*L-1:0] din;
  logic                din_valid;
  logic                din_ready;
  logic [DIGITS*N-1:0] R;
  logic                Re;

  modport master (output din, din_valid, Re, input din_ready, R);
  modport slave  (input din, din_valid, Re, output din_ready, R);
endinterface

// File: rtl/bin2qdi_1ofn_fifo.sv
// Clocked binary-to-QDI source: buffers binary words in a small FIFO and launches
// each as a multi-digit 1-of-N return-to-zero token, paced by a synchronised Re.
module bin2qdi_1ofn_fifo #(
  parameter int unsigned N           = 4,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  bin2qdi_1ofn_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            tok_count
);
  localparam int unsigned L  = $clog2(N);
  localparam int unsigned W  = DIGITS * L;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {S_NULL, S_DATA} state_t;

  state_t              state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                re_s;

  logic [W-1:0]        mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                full, empty, push, pop, clr;
  logic [W-1:0]        head;
  logic [DIGITS*N-1:0] enc, r_q;

  // Re synchroniser; all handshake decisions use re_s only
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], bus.Re};
  end
  assign re_s = sync[SYNC_STAGES-1];

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign bus.din_ready = ~full;
  assign push          = bus.din_valid & ~full;
  assign fifo_level    = count;
  assign head          = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // One rail per digit, selected by the digit's unsigned value
  always_comb begin
    enc = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      for (int unsigned v = 0; v < N; v++) begin
        enc[i*N + v] = (head[i*L +: L] == L'(v));
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= S_NULL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_NULL:  if (re_s && !empty) state_nxt = S_DATA;
      S_DATA:  if (!re_s)          state_nxt = S_NULL;
      default: state_nxt = S_NULL;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    clr = 1'b0;
    case (state)
      S_NULL:  pop = re_s & ~empty;
      S_DATA:  clr = ~re_s;
      default: clr = 1'b1;
    endcase
  end

  // Rails are registered so every rail of a token rises and falls on one edge
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_q       <= '0;
      tok_count <= '0;
    end else if (pop) begin
      r_q       <= enc;
      tok_count <= tok_count + 16'd1;
    end else if (clr) begin
      r_q       <= '0;
    end
  end

  assign bus.R = r_q;
endmodule

// File: tb/tb_bin2qdi_1ofn_fifo.sv
// Directed self-checking bench for bin2qdi_1ofn_fifo with N=4, DIGITS=2,
// DEPTH=4, SYNC_STAGES=2.
module tb_bin2qdi_1ofn_fifo;
  localparam int unsigned N = 4, DIGITS = 2, DEPTH = 4, SS = 2;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [2:0]  fifo_level;
  logic [15:0] tok_count;
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  w [5];

  always #5 CLK = ~CLK;

  bin2qdi_1ofn_fifo_if #(.N(N), .DIGITS(DIGITS)) bus ();

  bin2qdi_1ofn_fifo #(.N(N), .DIGITS(DIGITS), .DEPTH(DEPTH), .SYNC_STAGES(SS)) u_dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .bus        (bus),
    .fifo_level (fifo_level),
    .tok_count  (tok_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] x);
    enc = (8'd1 << x[1:0]) | (8'd1 << (3'd4 + {1'b0, x[3:2]}));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [3:0] x);
    bus.din       = x;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_r(input logic [7:0] exp, input string tag);
    for (int i = 0; i < 10; i++) begin
      if (bus.R === exp) break;
      tick();
    end
    chk(tag, 32'(bus.R), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    w[0] = 4'h1; w[1] = 4'h6; w[2] = 4'hB; w[3] = 4'hC; w[4] = 4'h7;

    // reset held with Re and din_valid active
    RESETn = 1'b0; bus.Re = 1'b1; bus.din_valid = 1'b1; bus.din = 4'hD;
    repeat (3) tick();
    chk("rst_R", 32'(bus.R), 0);
    chk("rst_ready", 32'(bus.din_ready), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_tok", 32'(tok_count), 0);
    bus.din_valid = 1'b0;
    RESETn = 1'b1;
    repeat (4) tick();
    chk("idle_R", 32'(bus.R), 0);

    // first token: 1 cycle from accept to launch; 4'b1101 -> 8'b1000_0010
    push(4'hD);
    chk("acc_level", 32'(fifo_level), 1);
    chk("acc_R", 32'(bus.R), 0);
    tick();
    chk("launch_R", 32'(bus.R), 32'h82);
    chk("launch_tok", 32'(tok_count), 1);
    chk("launch_level", 32'(fifo_level), 0);

    // Re fall reaches R after SYNC_STAGES+1 edges
    bus.Re = 1'b0;
    tick(); chk("fall_e1", 32'(bus.R), 32'h82);
    tick(); chk("fall_e2", 32'(bus.R), 32'h82);
    tick(); chk("fall_e3", 32'(bus.R), 0);

    // encoding sweep
    for (int v = 0; v < 16; v++) begin
      push(v[3:0]);
      bus.Re = 1'b1;
      wait_r(enc(v[3:0]), "sweep_tok");
      chk("sweep_ones", $countones(bus.R), 2);
      bus.Re = 1'b0;
      wait_r(8'h00, "sweep_null");
    end
    chk("sweep_tok_count", 32'(tok_count), 17);

    // full FIFO with Re low: fifth word ignored
    bus.din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.din = w[i];
      tick();
    end
    bus.din_valid = 1'b0;
    chk("full_ready", 32'(bus.din_ready), 0);
    chk("full_level", 32'(fifo_level), 4);
    bus.Re = 1'b1;
    tick();
    tick();
    chk("full_e2_R", 32'(bus.R), 0);
    chk("full_e2_ready", 32'(bus.din_ready), 0);
    tick();
    chk("full_pop_R", 32'(bus.R), 32'(enc(w[0])));
    chk("full_pop_ready", 32'(bus.din_ready), 1);
    chk("full_pop_level", 32'(fifo_level), 3);
    for (int i = 1; i < 4; i++) begin
      bus.Re = 1'b0;
      wait_r(8'h00, "order_null");
      bus.Re = 1'b1;
      wait_r(enc(w[i]), "order_tok");
    end
    bus.Re = 1'b0;
    wait_r(8'h00, "order_null");
    bus.Re = 1'b1;
    repeat (5) tick();
    chk("no_fifth_R", 32'(bus.R), 0);
    chk("no_fifth_level", 32'(fifo_level), 0);
    chk("order_tok_count", 32'(tok_count), 21);

    // sub-cycle Re pulse is invisible; one-cycle pulse yields exactly one token
    bus.Re = 1'b0;
    repeat (3) tick();
    push(4'h2);
    push(4'h9);
    chk("pulse_level0", 32'(fifo_level), 2);
    bus.Re = 1'b1;
    #3;
    bus.Re = 1'b0;
    repeat (5) tick();
    chk("glitch_R", 32'(bus.R), 0);
    chk("glitch_level", 32'(fifo_level), 2);
    bus.Re = 1'b1;
    tick();
    bus.Re = 1'b0;
    tick(); chk("pulse_e2", 32'(bus.R), 0);
    tick(); chk("pulse_e3", 32'(bus.R), 32'h14);
    tick(); chk("pulse_e4", 32'(bus.R), 0);
    repeat (4) tick();
    chk("pulse_R", 32'(bus.R), 0);
    chk("pulse_level", 32'(fifo_level), 1);
    chk("pulse_tok", 32'(tok_count), 22);

    // drain 4'h9, then build R=0x41 and reset mid-token
    bus.Re = 1'b1;
    wait_r(8'h42, "drain_tok");
    bus.Re = 1'b0;
    wait_r(8'h00, "drain_null");
    bus.Re = 1'b1;
    push(4'h8);
    push(4'h3);
    wait_r(8'h41, "pre_reset");
    #3;
    RESETn = 1'b0;
    #1;
    chk("async_R", 32'(bus.R), 0);
    chk("async_level", 32'(fifo_level), 0);
    chk("async_tok", 32'(tok_count), 0);
    chk("async_ready", 32'(bus.din_ready), 1);
    tick();
    RESETn = 1'b1;
    repeat (3) tick();
    chk("post_rst_R", 32'(bus.R), 0);
    chk("post_rst_level", 32'(fifo_level), 0);
    chk("post_rst_tok", 32'(tok_count), 0);

    // simultaneous push and pop keeps level
    push(4'h5);
    chk("sim_pre_level", 32'(fifo_level), 1);
    chk("sim_pre_R", 32'(bus.R), 0);
    push(4'hE);
    chk("sim_level", 32'(fifo_level), 1);
    chk("sim_R", 32'(bus.R), 32'h22);
    chk("sim_tok", 32'(tok_count), 1);
    tick();
    chk("hold_R", 32'(bus.R), 32'h22);
    chk("hold_level", 32'(fifo_level), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
